// File: rtl/bldcm_pkg.sv
// Shared types, constants and the commutation table for the six-step BLDC drive.
package bldcm_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StBrake = 2'd2
  } bldcm_state_e;

  localparam int unsigned NumPhases = 6;

  // Gate bit positions, order {Uh,Ul,Vh,Vl,Wh,Wl}.
  localparam int unsigned IdxUh = 5;
  localparam int unsigned IdxUl = 4;
  localparam int unsigned IdxVh = 3;
  localparam int unsigned IdxVl = 2;
  localparam int unsigned IdxWh = 1;
  localparam int unsigned IdxWl = 0;

  localparam logic [5:0] HighSideMask = 6'b101010;
  localparam logic [5:0] LowSideMask  = 6'b010101;

  // Switches closed in each phase: one high side (PWM-gated later) and one low side.
  function automatic logic [5:0] phase_switches(input logic [2:0] phase);
    logic [5:0] sw;
    sw = '0;
    case (phase)
      3'd0: begin sw[IdxUh] = 1'b1; sw[IdxVl] = 1'b1; end
      3'd1: begin sw[IdxUh] = 1'b1; sw[IdxWl] = 1'b1; end
      3'd2: begin sw[IdxVh] = 1'b1; sw[IdxWl] = 1'b1; end
      3'd3: begin sw[IdxVh] = 1'b1; sw[IdxUl] = 1'b1; end
      3'd4: begin sw[IdxWh] = 1'b1; sw[IdxUl] = 1'b1; end
      3'd5: begin sw[IdxWh] = 1'b1; sw[IdxVl] = 1'b1; end
      default: sw = '0;
    endcase
    return sw;
  endfunction

endpackage

// File: rtl/bldcm_deadtime.sv
// Rising-edge delay for one gate request; falling edges pass straight through.
module bldcm_deadtime #(
  parameter int unsigned pDeadTime = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic dly_o
);

  localparam logic [7:0] DeadCnt = 8'(pDeadTime);

  logic [7:0] cnt_q, cnt_d;

  // Count request-high cycles, saturating at the dead time; any low clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i) begin
      cnt_d = '0;
    end else if (cnt_q != DeadCnt) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign dly_o = req_i && (cnt_q == DeadCnt);

endmodule

// File: rtl/bldcm_ramp_commutator.sv
// Six-step BLDC engine: commutation timer with linear divider ramp, PWM,
// dead time and output polarity.
module bldcm_ramp_commutator
  import bldcm_pkg::*;
#(
  parameter int unsigned          pDivWidth   = 24,
  parameter int unsigned          pPwmWidth   = 16,
  parameter logic [pDivWidth-1:0] pStartDiv   = pDivWidth'(500000),
  parameter int unsigned          pDeadTime   = 10,
  parameter logic [5:0]           pInvertMask = 6'b000000
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iEnable,
  input  logic [pDivWidth-1:0] iTargetDiv,
  input  logic                 iLoadTarget,
  input  logic [pDivWidth-1:0] iStepDiv,
  input  logic                 iDir,
  input  logic                 iBrake,
  input  logic [pPwmWidth-1:0] iPwmMaxCnt,
  input  logic [pPwmWidth-1:0] iPwmCmp,
  output logic [2:0]           oPhase,
  output logic [pDivWidth-1:0] oCurDiv,
  output logic                 oRampBusy,
  output logic                 oStopped,
  output logic                 oUh,
  output logic                 oUl,
  output logic                 oVh,
  output logic                 oVl,
  output logic                 oWh,
  output logic                 oWl
);

  localparam logic [pDivWidth-1:0] DivOne = pDivWidth'(1);
  localparam logic [pDivWidth-1:0] DivMin = pDivWidth'(2);
  localparam logic [2:0]           LastPh = 3'(NumPhases - 1);

  bldcm_state_e         state_q, state_d;
  logic [2:0]           phase_q, phase_d;
  logic [pDivWidth-1:0] cur_div_q, cur_div_d;
  logic [pDivWidth-1:0] target_q, target_d;
  logic [pDivWidth-1:0] timer_q, timer_d;
  logic                 dir_q, dir_d;
  logic [pPwmWidth-1:0] pwm_cnt_q, pwm_cnt_d, pwm_max_q, pwm_max_d, pwm_cmp_q, pwm_cmp_d;
  logic [5:0]           gate_q, gate_d;

  logic [pDivWidth-1:0] eff_target, div_used, div_step;
  logic [2:0]           phase_next;
  logic                 timer_tc, pwm_wrap, pwm_on;
  logic [5:0]           req_raw, req_dly;

  assign eff_target = (target_q == '0) ? pStartDiv : target_q;
  assign div_used   = (cur_div_q < DivMin) ? DivMin : cur_div_q;
  assign timer_tc   = (timer_q == div_used - DivOne);

  // Next divider: one step toward the effective target, clamped so it never overshoots.
  always_comb begin
    div_step = cur_div_q;
    if (cur_div_q > eff_target) begin
      div_step = (cur_div_q - eff_target <= iStepDiv) ? eff_target : cur_div_q - iStepDiv;
    end else if (cur_div_q < eff_target) begin
      div_step = (eff_target - cur_div_q <= iStepDiv) ? eff_target : cur_div_q + iStepDiv;
    end
  end

  // Next phase in the latched direction, wrapping mod 6.
  always_comb begin
    if (dir_q) phase_next = (phase_q == 3'd0) ? LastPh : phase_q - 3'd1;
    else       phase_next = (phase_q == LastPh) ? 3'd0 : phase_q + 3'd1;
  end

  // Control FSM: next state, timer, phase and divider.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cur_div_d = cur_div_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
    target_d  = iLoadTarget ? iTargetDiv : target_q;
    if (iBrake) begin
      state_d = StBrake;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iEnable && (target_q != '0)) begin
            state_d   = StRun;
            dir_d     = iDir;
            cur_div_d = pStartDiv;
            timer_d   = '0;
          end
        end
        StRun: begin
          if (!iEnable) begin
            state_d = StIdle;
            timer_d = '0;
          end else if (timer_tc) begin
            timer_d = '0;
            // Ramped stop: decelerated back to the start divider with no target.
            if ((target_q == '0) && (cur_div_q >= pStartDiv)) begin
              state_d = StIdle;
            end else begin
              phase_d   = phase_next;
              cur_div_d = div_step;
            end
          end else begin
            timer_d = timer_q + DivOne;
          end
        end
        StBrake: begin
          state_d   = StIdle;
          cur_div_d = pStartDiv;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign pwm_wrap = (pwm_cnt_q >= pwm_max_q);
  assign pwm_on   = (pwm_cnt_q < pwm_cmp_q);

  // PWM counter; period and compare only take new values at wrap.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_max_d = pwm_max_q;
    pwm_cmp_d = pwm_cmp_q;
    if (pwm_wrap) begin
      pwm_cnt_d = '0;
      pwm_max_d = iPwmMaxCnt;
      pwm_cmp_d = iPwmCmp;
    end
  end

  // Raw gate requests before dead time.
  always_comb begin
    unique case (state_q)
      StRun:   req_raw = phase_switches(phase_q) & (LowSideMask | (pwm_on ? HighSideMask : '0));
      StBrake: req_raw = LowSideMask;
      default: req_raw = '0;
    endcase
  end

  for (genvar g = 0; g < 6; g++) begin : g_dt
    bldcm_deadtime #(
      .pDeadTime(pDeadTime)
    ) u_dt (
      .clk_i(iClock),
      .rst_i(iReset),
      .req_i(req_raw[g]),
      .dly_o(req_dly[g])
    );
  end

  assign gate_d = req_dly ^ pInvertMask;

  // State registers; gates reset straight to their inactive level.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      cur_div_q <= pStartDiv;
      target_q  <= '0;
      timer_q   <= '0;
      dir_q     <= 1'b0;
      pwm_cnt_q <= '0;
      pwm_max_q <= '0;
      pwm_cmp_q <= '0;
      gate_q    <= pInvertMask;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cur_div_q <= cur_div_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_max_q <= pwm_max_d;
      pwm_cmp_q <= pwm_cmp_d;
      gate_q    <= gate_d;
    end
  end

  assign oPhase    = phase_q;
  assign oCurDiv   = cur_div_q;
  assign oRampBusy = (state_q == StRun) && (cur_div_q != target_q);
  assign oStopped  = (state_q == StIdle);
  assign oUh       = gate_q[IdxUh];
  assign oUl       = gate_q[IdxUl];
  assign oVh       = gate_q[IdxVh];
  assign oVl       = gate_q[IdxVl];
  assign oWh       = gate_q[IdxWh];
  assign oWl       = gate_q[IdxWl];

endmodule

// File: tb/tb_bldcm_ramp_commutator.sv
// Directed bench for bldcm_ramp_commutator (start divider 100, dead time 10, mask 101010).
module tb_bldcm_ramp_commutator;

  localparam logic [5:0] Mask = 6'b101010;

  logic        clk = 1'b0;
  logic        rst, en, ld, dir, brake;
  logic [23:0] tgt, step;
  logic [15:0] pmax, pcmp;
  logic [2:0]  phase;
  logic [23:0] cur_div;
  logic        busy, stopped;
  logic        uh, ul, vh, vl, wh, wl;
  logic [5:0]  gates, act;

  int checks   = 0;
  int failures = 0;
  int ov_leg   = 0;

  always #5 clk = ~clk;

  bldcm_ramp_commutator #(
    .pDivWidth  (24),
    .pPwmWidth  (16),
    .pStartDiv  (24'd100),
    .pDeadTime  (10),
    .pInvertMask(Mask)
  ) dut (
    .iClock     (clk),
    .iReset     (rst),
    .iEnable    (en),
    .iTargetDiv (tgt),
    .iLoadTarget(ld),
    .iStepDiv   (step),
    .iDir       (dir),
    .iBrake     (brake),
    .iPwmMaxCnt (pmax),
    .iPwmCmp    (pcmp),
    .oPhase     (phase),
    .oCurDiv    (cur_div),
    .oRampBusy  (busy),
    .oStopped   (stopped),
    .oUh        (uh),
    .oUl        (ul),
    .oVh        (vh),
    .oVl        (vl),
    .oWh        (wh),
    .oWl        (wl)
  );

  assign gates = {uh, ul, vh, vl, wh, wl};
  assign act   = gates ^ Mask;

  // Both switches of one leg active at once is never allowed.
  always @(negedge clk) begin
    if (!rst && ((act[5] && act[4]) || (act[3] && act[2]) || (act[1] && act[0]))) ov_leg++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Negedges until oPhase changes; -1 on timeout.
  task automatic wait_phase(output int n);
    logic [2:0] prev;
    prev = phase;
    n = 0;
    while (phase == prev && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (phase == prev) n = -1;
  endtask

  task automatic wait_stopped(input logic val, output int n);
    n = 0;
    while (stopped !== val && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (stopped !== val) n = -1;
  endtask

  task automatic wait_uh(input logic val, output int n);
    n = 0;
    while (act[5] !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (act[5] !== val) n = -1;
  endtask

  // Load a target and request run; returns on the first RUN cycle (timer at 0).
  task automatic start_run(input logic [23:0] t, input logic [23:0] s, input logic d);
    int n;
    @(negedge clk);
    tgt = t; step = s; dir = d; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    wait_stopped(1'b0, n);
    chk("start_run", n, 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int         n;
  int         cnt;
  logic [5:0] hist [12];
  int         per_exp [5] = '{100, 80, 60, 40, 40};
  int         div_exp [5] = '{80, 60, 40, 40, 40};

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; dir = 1'b0; brake = 1'b0;
    tgt = '0; step = '0; pmax = 16'd29; pcmp = 16'd13;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gates", gates, 6'b101010);
    chk("rst_stopped", stopped, 1);
    chk("rst_curdiv", cur_div, 100);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // Forward run, target 300 with step 250: saturates at 300, no overshoot
    start_run(24'd300, 24'd250, 1'b0);
    repeat (45) @(negedge clk);
    chk("vl_on_phase0", act[2], 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (act[5]) cnt++;
    end
    // 13 raw counts minus 10 dead-time cycles per 30-cycle PWM period
    chk("uh_duty_cmp13", cnt, 3);
    wait_phase(n);
    chk("first_period_rest", n, 25);
    chk("phase_after_ev1", phase, 1);
    chk("div_saturated", cur_div, 300);

    // Dead time at phase 0->1: Vl off after 1 cycle, Wl on after 11
    hist[0] = act;
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      hist[k] = act;
    end
    chk("vl_k0", hist[0][2], 1);
    chk("vl_k1", hist[1][2], 0);
    chk("wl_k10", hist[10][0], 0);
    chk("wl_k11", hist[11][0], 1);
    cnt = 0;
    for (int k = 0; k < 12; k++) if (hist[k][2] && hist[k][0]) cnt++;
    chk("vl_wl_overlap", cnt, 0);

    // Compare raised above max just after Uh falls: applies only at wrap
    wait_uh(1'b1, n);
    chk("uh_rise_seen", (n >= 0), 1);
    wait_uh(1'b0, n);
    chk("uh_fall_seen", (n >= 0), 1);
    pcmp = 16'd40;
    wait_uh(1'b1, n);
    chk("cmp_at_wrap_latency", n, 27);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (act[5]) cnt++;
    end
    chk("uh_duty_full", cnt, 30);

    // Brake from RUN: highs off, all lows on after dead time
    @(negedge clk); brake = 1'b1;
    repeat (11) @(negedge clk);
    chk("brake_k11", act, 6'b000001);
    @(negedge clk);
    chk("brake_k12", act, 6'b010101);
    chk("brake_not_idle", stopped, 0);
    @(negedge clk); en = 1'b0;
    @(negedge clk); brake = 1'b0;
    @(negedge clk);
    chk("unbrake_idle", stopped, 1);
    chk("unbrake_div", cur_div, 100);
    @(negedge clk);
    chk("unbrake_gates_off", act, 0);

    // Ramp 100 -> 40 by 20
    reset_pulse();
    start_run(24'd40, 24'd20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_phase(n);
      chk("ramp_period", n, per_exp[i]);
      chk("ramp_phase", phase, i + 1);
      chk("ramp_div", cur_div, div_exp[i]);
      chk("ramp_busy", busy, (i < 2) ? 1 : 0);
    end

    // Ramped stop: target 0, step 30 -> 70, 100, then IDLE
    tgt = '0; step = 24'd30; ld = 1'b1;
    wait_phase(n);
    ld = 1'b0;
    chk("stop_period40", n, 40);
    chk("stop_phase_wrap", phase, 0);
    chk("stop_div70", cur_div, 70);
    wait_phase(n);
    chk("stop_period70", n, 70);
    chk("stop_div100", cur_div, 100);
    wait_stopped(1'b1, n);
    chk("stop_period100", n, 100);
    chk("stop_phase_kept", phase, 1);
    @(negedge clk);
    chk("stop_gates_off", gates, 6'b101010);

    // Reverse from phase 0; iDir toggled mid-run is ignored
    reset_pulse();
    start_run(24'd100, 24'd0, 1'b1);
    wait_phase(n);
    chk("rev_period", n, 100);
    chk("rev_phase5", phase, 5);
    dir = 1'b0;
    wait_phase(n);
    chk("rev_phase4", phase, 4);
    wait_phase(n);
    chk("rev_phase3", phase, 3);
    chk("rev_div_hold", cur_div, 100);

    // Enable drop stops at once; restart relatches direction
    en = 1'b0;
    @(negedge clk);
    chk("en_drop_idle", stopped, 1);
    chk("en_drop_phase", phase, 3);
    en = 1'b1;
    wait_stopped(1'b0, n);
    chk("restart", n, 1);
    wait_phase(n);
    chk("restart_period", n, 100);
    chk("restart_fwd_phase", phase, 4);

    // Asynchronous reset mid-run, away from any clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_gates", gates, 6'b101010);
    chk("async_phase", phase, 0);
    chk("async_stopped", stopped, 1);
    @(negedge clk); rst = 1'b0; en = 1'b0;

    chk("leg_overlap", ov_leg, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
